// File: rtl/tc_spi_responder_if.sv
// SPI pin bundle between a mode-1 SPI master and the thermocouple/RTD ADC
// responder. The master drives chip select, clock and MOSI; the responder
// drives MISO.
interface tc_spi_responder_if;
  logic spi_csn;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_miso;

  modport master (
    output spi_csn,
    output spi_sclk,
    output spi_mosi,
    input  spi_miso
  );

  modport slave (
    input  spi_csn,
    input  spi_sclk,
    input  spi_mosi,
    output spi_miso
  );
endinterface : tc_spi_responder_if

// File: rtl/tc_spi_responder.sv
// SPI mode-1 responder emulating the thermocouple/RTD ADC. The pins are
// oversampled in the clk domain. The responder returns the word last loaded
// through tx_load, and it hands each complete received word to the fabric on
// rx_data/rx_valid. A frame with the wrong bit count raises frame_err.
module tc_spi_responder #(
  parameter int   DATA_WIDTH = 16,
  parameter logic IDLE_MISO  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tc_spi_responder_if.slave     spi,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int             CW   = $clog2(DATA_WIDTH + 2);
  localparam logic [CW-1:0]  FULL = CW'(DATA_WIDTH);
  localparam logic [CW-1:0]  OVER = CW'(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_OVERRUN
  } state_t;

  // Pin synchronizers; stage 3 on csn/sclk exists only for edge detection
  logic       r_csn_s1, r_csn_s2, r_csn_s3;
  logic       r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic       r_mosi_s1, r_mosi_s2;
  // Warm-up: r_csn_s2 reflects a real pin sample only after two edges
  logic [1:0] r_warm;
  // Set once CSN has been seen high after reset, so a frame already running
  // on the pins at reset release is ignored
  logic       r_armed;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_tx_shift, w_tx_shift_nxt;
  logic [DATA_WIDTH-1:0] r_rx_shift, w_rx_shift_nxt;
  logic [DATA_WIDTH-1:0] r_rx_data, w_rx_data_nxt;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_miso, w_miso_nxt;
  logic                  r_rx_valid, w_rx_valid_nxt;
  logic                  r_frame_err, w_frame_err_nxt;
  logic                  r_first_seen, w_first_seen_nxt;

  logic          w_csn_fall, w_csn_rise, w_sclk_rise, w_sclk_fall;
  logic [CW-1:0] w_cnt_inc;

  // Synchronize asynchronous SPI pins into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csn_s1  <= 1'b1;
      r_csn_s2  <= 1'b1;
      r_csn_s3  <= 1'b1;
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_s3 <= 1'b0;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
      r_warm    <= 2'b00;
      r_armed   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage read the previous
      // value of its neighbour, which is what makes this a shift chain.
      r_csn_s1  <= spi.spi_csn;
      r_csn_s2  <= r_csn_s1;
      r_csn_s3  <= r_csn_s2;
      r_sclk_s1 <= spi.spi_sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_mosi_s1 <= spi.spi_mosi;
      r_mosi_s2 <= r_mosi_s1;
      r_warm    <= {r_warm[0], 1'b1};
      if (r_warm[1] && r_csn_s2) r_armed <= 1'b1;
    end
  end

  assign w_csn_fall  = r_armed & r_csn_s3 & ~r_csn_s2;
  assign w_csn_rise  = ~r_csn_s3 & r_csn_s2;
  assign w_sclk_rise = ~r_sclk_s3 & r_sclk_s2;
  assign w_sclk_fall = r_sclk_s3 & ~r_sclk_s2;
  assign w_cnt_inc   = r_cnt + CW'(1);

  // Holding register; sampled only at frame start, so loads never disturb a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_hold <= '0;
    else if (tx_load) r_hold <= tx_data;
  end

  // Frame FSM state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_tx_shift   <= '0;
      r_rx_shift   <= '0;
      r_rx_data    <= '0;
      r_miso       <= IDLE_MISO;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_first_seen <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_tx_shift   <= w_tx_shift_nxt;
      r_rx_shift   <= w_rx_shift_nxt;
      r_rx_data    <= w_rx_data_nxt;
      r_miso       <= w_miso_nxt;
      r_rx_valid   <= w_rx_valid_nxt;
      r_frame_err  <= w_frame_err_nxt;
      r_first_seen <= w_first_seen_nxt;
    end
  end

  // Next-state and next-output logic; CSN rise beats any SCLK edge in the same cycle
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_tx_shift_nxt   = r_tx_shift;
    w_rx_shift_nxt   = r_rx_shift;
    w_rx_data_nxt    = r_rx_data;
    w_miso_nxt       = r_miso;
    w_rx_valid_nxt   = 1'b0;
    w_frame_err_nxt  = 1'b0;
    w_first_seen_nxt = r_first_seen;

    if ((r_state != ST_IDLE) && w_csn_rise) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_miso_nxt  = IDLE_MISO;
      if (r_cnt == FULL) begin
        w_rx_data_nxt  = r_rx_shift;
        w_rx_valid_nxt = 1'b1;
      end else begin
        w_frame_err_nxt = 1'b1;
      end
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_miso_nxt       = IDLE_MISO;
          w_cnt_nxt        = '0;
          w_first_seen_nxt = 1'b0;
          if (w_csn_fall) begin
            w_tx_shift_nxt = r_hold;
            w_miso_nxt     = r_hold[DATA_WIDTH-1];
            w_state_nxt    = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_sclk_rise) begin
            // The first rising edge keeps the MSB already on the pin
            if (r_first_seen) begin
              w_tx_shift_nxt = {r_tx_shift[DATA_WIDTH-2:0], r_tx_shift[DATA_WIDTH-1]};
              w_miso_nxt     = r_tx_shift[DATA_WIDTH-2];
            end else begin
              w_first_seen_nxt = 1'b1;
            end
          end else if (w_sclk_fall) begin
            w_rx_shift_nxt = {r_rx_shift[DATA_WIDTH-2:0], r_mosi_s2};
            w_cnt_nxt      = w_cnt_inc;
            if (w_cnt_inc == FULL) begin
              w_state_nxt = ST_OVERRUN;
              w_miso_nxt  = 1'b0;
            end
          end
        end
        ST_OVERRUN: begin
          w_miso_nxt = 1'b0;
          if (w_sclk_fall && (r_cnt == FULL)) w_cnt_nxt = OVER;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign spi.spi_miso = r_miso;
  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign frame_err    = r_frame_err;
  assign busy         = (r_state != ST_IDLE);

endmodule : tc_spi_responder

// File: tb/tb_tc_spi_responder.sv
// Testbench for tc_spi_responder. A behavioural mode-1 SPI master drives
// frames at SCLK = clk/10. The bench compares results against a table of
// hand-derived vectors, a few multi-cycle corner sequences, and a randomized
// run that is checked against a word-level reference model.
module tb_tc_spi_responder;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] tx_data;
  logic          tx_load;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          busy;

  always #5 clk = ~clk;

  tc_spi_responder_if spi_bus ();

  tc_spi_responder #(.DATA_WIDTH(DW), .IDLE_MISO(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi       (spi_bus),
    .tx_data   (tx_data),
    .tx_load   (tx_load),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse monitor: counts and shape of rx_valid / frame_err
  int   n_valid = 0, n_err = 0, n_both = 0, n_wide = 0;
  logic prev_v = 1'b0, prev_e = 1'b0;
  always @(negedge clk) begin
    if (rx_valid === 1'b1)                n_valid <= n_valid + 1;
    if (frame_err === 1'b1)               n_err   <= n_err + 1;
    if (rx_valid === 1'b1 && frame_err === 1'b1) n_both <= n_both + 1;
    if ((rx_valid === 1'b1 && prev_v) || (frame_err === 1'b1 && prev_e))
      n_wide <= n_wide + 1;
    prev_v <= (rx_valid === 1'b1);
    prev_e <= (frame_err === 1'b1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Tick scheduler: every input change happens just after a falling clk edge
  int            tick_n = 0;
  int            ld_at  = -1;
  logic [DW-1:0] ld_val = '0;

  task automatic tick();
    @(negedge clk);
    tick_n++;
    if (tick_n == ld_at) begin
      tx_data = ld_val;
      tx_load = 1'b1;
    end else begin
      tx_load = 1'b0;
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load_word(input logic [DW-1:0] v);
    @(negedge clk);
    tx_data = v;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  // One SCLK period: MOSI changes on the rise, MISO is sampled at the fall
  task automatic sclk_bit(input logic b, output logic m);
    spi_bus.spi_sclk = 1'b1;
    spi_bus.spi_mosi = b;
    wait_ticks(5);
    m = spi_bus.spi_miso;
    spi_bus.spi_sclk = 1'b0;
    wait_ticks(5);
  endtask

  logic [31:0] f_miso;
  int          f_lat, f_dv, f_de;
  logic        f_busy;

  task automatic spi_frame(input int nbits, input logic [31:0] mosi,
                           input int load_at, input logic [DW-1:0] load_val);
    int   v0, e0;
    logic m;
    tick();
    tick_n = 0;
    ld_at  = load_at;
    ld_val = load_val;
    v0     = n_valid;
    e0     = n_err;
    f_miso = '0;
    f_lat  = -1;
    spi_bus.spi_csn = 1'b0;
    wait_ticks(5);
    f_busy = busy;
    for (int i = 0; i < nbits; i++) begin
      sclk_bit(mosi[nbits-1-i], m);
      f_miso = {f_miso[30:0], m};
    end
    wait_ticks(5);
    spi_bus.spi_csn = 1'b1;
    for (int i = 1; i <= 10 && f_lat < 0; i++) begin
      tick();
      if (rx_valid === 1'b1 || frame_err === 1'b1) f_lat = i;
    end
    wait_ticks(6);
    ld_at = -1;
    f_dv  = n_valid - v0;
    f_de  = n_err - e0;
  endtask

  typedef struct {
    logic          do_load;
    logic [DW-1:0] load_val;
    int            nbits;
    logic [31:0]   mosi;
    logic [31:0]   exp_miso;
    logic          exp_valid;
    logic          exp_err;
    logic [DW-1:0] exp_rx;
  } vec_t;

  vec_t vecs[8];

  // Watchdog: the bench must never hang
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          m;
    int            v0, e0, nb, la;
    logic [31:0]   mosi, mask, exp_miso;
    logic [DW-1:0] m_hold, m_rx, f_hold, lv;

    vecs[0] = '{1'b1, 16'hA55A, 16, 32'h8583,  32'hA55A,  1'b1, 1'b0, 16'h8583};
    vecs[1] = '{1'b0, 16'h0000, 12, 32'h0ABC,  32'h0A55,  1'b0, 1'b1, 16'h8583};
    vecs[2] = '{1'b1, 16'h0F0F, 20, 32'hFFFFF, 32'h0F0F0, 1'b0, 1'b1, 16'h8583};
    vecs[3] = '{1'b0, 16'h0000, 16, 32'h3C3C,  32'h0F0F,  1'b1, 1'b0, 16'h3C3C};
    vecs[4] = '{1'b1, 16'hFFFF, 16, 32'h0000,  32'hFFFF,  1'b1, 1'b0, 16'h0000};
    vecs[5] = '{1'b1, 16'h0000, 1,  32'h0001,  32'h0000,  1'b0, 1'b1, 16'h0000};
    vecs[6] = '{1'b0, 16'h0000, 17, 32'h1FFFF, 32'h00000, 1'b0, 1'b1, 16'h0000};
    vecs[7] = '{1'b1, 16'h8001, 16, 32'h7FFE,  32'h8001,  1'b1, 1'b0, 16'h7FFE};

    rst_n            = 1'b0;
    tx_data          = '0;
    tx_load          = 1'b0;
    spi_bus.spi_csn  = 1'b1;
    spi_bus.spi_sclk = 1'b0;
    spi_bus.spi_mosi = 1'b0;

    // Reset held while the master toggles CSN/SCLK: outputs stay idle
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      spi_bus.spi_csn  = ~spi_bus.spi_csn;
      spi_bus.spi_sclk = ~spi_bus.spi_sclk;
    end
    check("reset_miso", 32'(spi_bus.spi_miso), 32'h1);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_rx_data", 32'(rx_data), 32'h0);
    check("reset_no_pulses", 32'(n_valid + n_err), 32'h0);
    spi_bus.spi_csn  = 1'b1;
    spi_bus.spi_sclk = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(8);

    // Table-driven frames
    for (int k = 0; k < 8; k++) begin
      if (vecs[k].do_load) load_word(vecs[k].load_val);
      check($sformatf("v%0d_idle_miso", k), 32'(spi_bus.spi_miso), 32'h1);
      spi_frame(vecs[k].nbits, vecs[k].mosi, -1, '0);
      check($sformatf("v%0d_miso", k), f_miso, vecs[k].exp_miso);
      check($sformatf("v%0d_busy", k), 32'(f_busy), 32'h1);
      check($sformatf("v%0d_rx_valid", k), 32'(f_dv), 32'(vecs[k].exp_valid));
      check($sformatf("v%0d_frame_err", k), 32'(f_de), 32'(vecs[k].exp_err));
      check($sformatf("v%0d_rx_data", k), 32'(rx_data), 32'(vecs[k].exp_rx));
      if (k == 0) check("v0_latency", 32'(f_lat), 32'd3);
      check($sformatf("v%0d_busy_after", k), 32'(busy), 32'h0);
    end

    // Back-to-back: mid-frame load goes to the next frame; a load coincident
    // with the synchronized CSN fall also waits one frame
    load_word(16'hA55A);
    spi_frame(16, 32'h1111, 30, 16'h1234);
    check("b2b1_miso", f_miso, 32'hA55A);
    check("b2b1_latency", 32'(f_lat), 32'd3);
    spi_frame(16, 32'h2222, 2, 16'h5678);
    check("b2b2_miso", f_miso, 32'h1234);
    spi_frame(16, 32'h3333, -1, '0);
    check("b2b3_miso", f_miso, 32'h5678);
    check("b2b3_rx_data", 32'(rx_data), 32'h3333);

    // Abort: reset after 8 bits, pins left mid-frame across reset release
    load_word(16'hBEEF);
    tick();
    tick_n = 0;
    spi_bus.spi_csn = 1'b0;
    wait_ticks(5);
    for (int i = 0; i < 8; i++) sclk_bit(1'b1, m);
    v0 = n_valid;
    e0 = n_err;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_miso", 32'(spi_bus.spi_miso), 32'h1);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_rx_data", 32'(rx_data), 32'h0);
    wait_ticks(3);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) sclk_bit(1'b0, m);
    check("abort_ignored_busy", 32'(busy), 32'h0);
    check("abort_ignored_miso", 32'(spi_bus.spi_miso), 32'h1);
    spi_bus.spi_csn = 1'b1;
    wait_ticks(10);
    check("abort_no_pulses", 32'((n_valid - v0) + (n_err - e0)), 32'h0);
    spi_frame(16, 32'h5AA5, -1, '0);
    check("abort_next_miso", f_miso, 32'h0000);
    check("abort_next_valid", 32'(f_dv), 32'h1);
    check("abort_next_rx", 32'(rx_data), 32'h5AA5);

    // Randomized frames checked against a word-level model
    m_hold = '0;
    m_rx   = 16'h5AA5;
    for (int k = 0; k < 24; k++) begin
      nb   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 24)) : DW;
      mask = (32'd1 << nb) - 32'd1;
      mosi = $urandom & mask;
      if ($urandom_range(0, 3) == 0) begin
        lv = DW'($urandom);
        load_word(lv);
        m_hold = lv;
      end
      la = ($urandom_range(0, 2) == 0) ? int'($urandom_range(3, 5 + 10 * nb)) : -1;
      lv = DW'($urandom);
      f_hold = m_hold;
      spi_frame(nb, mosi, la, lv);
      if (la >= 0) m_hold = lv;
      exp_miso = '0;
      for (int i = 0; i < nb; i++)
        exp_miso = {exp_miso[30:0], (i < DW) ? f_hold[DW-1-i] : 1'b0};
      if (nb == DW) m_rx = mosi[DW-1:0];
      check($sformatf("rnd%0d_miso(n=%0d)", k, nb), f_miso, exp_miso);
      check($sformatf("rnd%0d_valid", k), 32'(f_dv), (nb == DW) ? 32'd1 : 32'd0);
      check($sformatf("rnd%0d_err", k), 32'(f_de), (nb == DW) ? 32'd0 : 32'd1);
      check($sformatf("rnd%0d_rx_data", k), 32'(rx_data), 32'(m_rx));
    end

    check("pulses_exclusive", 32'(n_both), 32'h0);
    check("pulses_one_cycle", 32'(n_wide), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_tc_spi_responder

// File: doc/tc_spi_responder.md
# tc_spi_responder

Synthesizable SPI peripheral (slave) emulating the thermocouple/RTD ADC at the far end of the GX_*_SPI buses. It lets the lxi_b SPI masters run in loopback, self-test and simulation without external ADC boards. The block oversamples SCLK/CSN/MOSI in the fabric clock domain, returns a parallel word supplied by the fabric, and hands the received command word back to the fabric.

## Interface
- DATA_WIDTH, 16: bits per frame, MSB first; valid range 8..32.
- IDLE_MISO, 1'b1: MISO level while CSN is high.
- clk  in  1  fabric clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- spi_csn  in  1  chip select from master, active low, asynchronous to clk.
- spi_sclk  in  1  SPI clock, mode 1 (CPOL=0, CPHA=1), asynchronous to clk.
- spi_mosi  in  1  master-to-responder data.
- spi_miso  out  1  responder-to-master data.
- tx_data  in  DATA_WIDTH  word returned in the next frame.
- tx_load  in  1  one-cycle strobe; latches tx_data into the holding register.
- rx_data  out  DATA_WIDTH  last complete received word.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- frame_err  out  1  one-cycle pulse on a frame with wrong bit count.
- busy  out  1  high while a frame is in progress (synchronized CSN low).

## Operation
- spi_csn, spi_sclk, spi_mosi each pass through a 2-FF synchronizer; a third register on csn/sclk provides edge detection. Synchronizer flops reset to csn=1, sclk=0, mosi=0.
- Holding register hold_q: written by tx_load; tx_load takes effect on the next frame only, never mid-frame. Reset value 0.
- States: IDLE, SHIFT, OVERRUN.
- IDLE: spi_miso=IDLE_MISO, bit counter=0. On synchronized CSN falling edge: tx_shift <= hold_q, drive spi_miso=hold_q[DATA_WIDTH-1], go SHIFT.
- SHIFT: on synchronized SCLK rising edge after the first, shift tx_shift left and drive the next bit (first rising edge keeps the MSB; mode 1 master samples on falling edge). On SCLK falling edge: rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_sync}, counter +1. When counter reaches DATA_WIDTH, go OVERRUN.
- OVERRUN: further SCLK edges ignored; spi_miso=0; counter saturates at DATA_WIDTH+1 if any extra falling edge occurs.
- On synchronized CSN rising edge in any non-IDLE state: counter==DATA_WIDTH -> rx_data <= rx_shift, rx_valid pulse; otherwise (short or extra bits) frame_err pulse, rx_data unchanged. Return to IDLE.
- CSN rising and SCLK edge detected in the same cycle: CSN wins, SCLK edge discarded.
- tx_load in the same cycle as CSN falling edge: frame uses old hold_q; new value held for the following frame.
- Reset mid-frame: all state returns to IDLE immediately; no rx_valid/frame_err emitted for the aborted frame; a frame already in progress on the pins when rst_n releases is ignored until CSN is seen high then low.

## Timing
- Reset values: spi_miso=IDLE_MISO, rx_data=0, rx_valid=0, frame_err=0, busy=0.
- Pin-to-action latency: 3 clk rising edges from first clk sampling a new pin level to the registered response (spi_miso update, busy change, rx_valid).
- Requirements on master: SCLK high and low phases each >= 4 clk periods; CSN-low to first SCLK rise >= 4 clk; last SCLK fall to CSN rise >= 4 clk; CSN high >= 4 clk between frames.
- MISO valid at most 3 clk after SCLK rise; master samples at next fall, so setup margin >= 1 clk.
- rx_valid and frame_err are exactly one cycle wide and mutually exclusive.
- tx_load accepted every cycle; no back-pressure.

## Test plan
- Reset: hold rst_n=0 with CSN toggling -> spi_miso=1, busy=0, no pulses; release, one 16-bit frame -> normal response.
- Basic frame: tx_load 16'hA55A, master sends 16'h8583 at SCLK=clk/10 -> master reads 16'hA55A, rx_data=16'h8583, one rx_valid pulse ~3 clk after CSN rise.
- Back-to-back: tx_load 16'h1234 during frame 1 (which returns 16'hA55A), frame 2 -> returns 16'h1234; tx_load coincident with CSN fall -> old value returned.
- Short frame: 12 SCLKs then CSN high -> frame_err pulse, rx_data keeps 16'h8583, no rx_valid.
- Long frame: 20 SCLKs -> bits 17..20 on MISO are 0, frame_err pulse, rx_data unchanged.
- Abort: rst_n asserted after 8 bits -> immediate IDLE outputs; subsequent full frame after CSN high returns hold_q=0 and rx_valid with correct rx_data.
